approx_adder_err_scan: RTL and testbench

//  On-chip stimulus and checker for an N-bit approximate adder.
//  - Sweeps all 2^(2N) operand pairs into an external approximate adder.
//  - Compares each result against an internally computed exact A+B.
//  - Accumulates error count, max error distance, sum of error distances, and first failing vector.
//  - Sits beside the adder under characterisation; results are read by the SoC after o_done.

---
 rtl/approx_adder_err_scan.sv | 190 +++++++++++++++++++
 tb/tb_approx_adder_err_scan.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_scan.sv
// ---------------------------------------------------------------------------
// approx_adder_err_scan
//
// Purpose:
//   On-chip stimulus generator and checker for an N-bit approximate adder.
//   It sweeps every operand pair {A,B} into an external adder. It compares
//   each returned {Cout,Sum} against the exact A+B. It accumulates these
//   results:
//     - the error count,
//     - the largest error distance,
//     - the sum of error distances,
//     - the index of the first failing vector.
//   Results are frozen once the sweep completes and stay readable until the
//   next start.
//
// Parameters:
//   N    operand width of the adder under test
//   LAT  cycles from an operand change to a valid adder result (>= 1)
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_rst_n          synchronous active-low reset
//   i_start          level start request, only honoured in IDLE
//   o_busy           sweep in progress
//   o_done           sweep complete, results valid and held
//   o_A, o_B         registered operands driven to the adder under test
//   i_Sum, i_Cout    result returned by the adder under test
//   o_err_cnt        number of vectors whose result differed from A+B
//   o_max_err        largest |result - (A+B)| seen
//   o_err_sum        sum of |result - (A+B)| over the sweep
//   o_first_err_vld  at least one error has been seen
//   o_first_err_idx  vector index {A,B} of the first error
// ---------------------------------------------------------------------------
module approx_adder_err_scan #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [N-1:0]     o_A,
    output logic [N-1:0]     o_B,
    input  logic [N-1:0]     i_Sum,
    input  logic             i_Cout,
    output logic [2*N:0]     o_err_cnt,
    output logic [N:0]       o_max_err,
    output logic [3*N:0]     o_err_sum,
    output logic             o_first_err_vld,
    output logic [2*N-1:0]   o_first_err_idx
);

    // The cycle counter must be able to hold LAT itself.
    localparam int CW = $clog2(LAT + 2);

    localparam logic [CW-1:0]  C_LAST  = CW'(LAT);
    localparam logic [CW-1:0]  C_ONE   = CW'(1);
    localparam logic [2*N-1:0] V_LAST  = '1;
    localparam logic [2*N-1:0] V_ONE   = (2*N)'(1);
    localparam logic [2*N:0]   CNT_ONE = (2*N+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [2*N-1:0] vec;
    logic [CW-1:0]  cnt;

    logic [N:0] exact_sum;
    logic [N:0] got_sum;
    logic [N:0] err_dist;
    logic       cmp_now;
    logic       last_vec;

    // The operands come straight from the vector register. This keeps the
    // exact reference in step with what the adder is actually seeing.
    assign o_A = vec[2*N-1:N];
    assign o_B = vec[N-1:0];

    // Exact reference, absolute error distance and compare/sweep-end strobes.
    always_comb begin
        exact_sum = {1'b0, o_A} + {1'b0, o_B};
        got_sum   = {i_Cout, i_Sum};
        if (got_sum >= exact_sum) begin
            err_dist = got_sum - exact_sum;
        end else begin
            err_dist = exact_sum - got_sum;
        end
        cmp_now  = (state == RUN) && (cnt == C_LAST);
        last_vec = (vec == V_LAST);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs. DONE waits for i_start to drop, so a
    // start held high yields exactly one sweep.
    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (cmp_now && last_vec) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                if (!i_start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector walk and result accumulation.
    // Each vector is held for LAT+1 cycles and compared on its last cycle.
    // On the final vector the operands are left in place.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vec             <= '0;
            cnt             <= '0;
            o_err_cnt       <= '0;
            o_max_err       <= '0;
            o_err_sum       <= '0;
            o_first_err_vld <= 1'b0;
            o_first_err_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        vec             <= '0;
                        cnt             <= '0;
                        o_err_cnt       <= '0;
                        o_max_err       <= '0;
                        o_err_sum       <= '0;
                        o_first_err_vld <= 1'b0;
                        o_first_err_idx <= '0;
                    end
                end
                RUN: begin
                    if (cmp_now) begin
                        if (err_dist != '0) begin
                            o_err_cnt <= o_err_cnt + CNT_ONE;
                            o_err_sum <= o_err_sum + (3*N+1)'(err_dist);
                            if (err_dist > o_max_err) begin
                                o_max_err <= err_dist;
                            end
                            if (!o_first_err_vld) begin
                                o_first_err_vld <= 1'b1;
                                o_first_err_idx <= vec;
                            end
                        end
                        if (!last_vec) begin
                            vec <= vec + V_ONE;
                        end
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_adder_err_scan.sv
// ---------------------------------------------------------------------------
// tb_approx_adder_err_scan
//
// Purpose:
//   Self-checking bench for approx_adder_err_scan with N=4.
//
//   dut1 uses LAT=1. It drives a combinational behavioural adder that can be
//   switched between several models:
//     - exact,
//     - low-bit truncating,
//     - stuck-at-0 carry,
//     - randomly faulted.
//   The expected results for each model come from a plain double loop over
//   every operand pair.
//
//   dut2 uses LAT=2 and is wired to a registered exact adder.
// ---------------------------------------------------------------------------
module tb_approx_adder_err_scan;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic start1;
    logic start2;

    logic         busy1;
    logic         done1;
    logic [3:0]   a1;
    logic [3:0]   b1;
    logic [3:0]   sum1;
    logic         cout1;
    logic [8:0]   err_cnt1;
    logic [4:0]   max_err1;
    logic [12:0]  err_sum1;
    logic         first_vld1;
    logic [7:0]   first_idx1;

    logic         busy2;
    logic         done2;
    logic [3:0]   a2;
    logic [3:0]   b2;
    logic [3:0]   sum2;
    logic         cout2;
    logic [8:0]   err_cnt2;
    logic [4:0]   max_err2;
    logic [12:0]  err_sum2;
    logic         first_vld2;
    logic [7:0]   first_idx2;

    int         adder_mode;
    logic [4:0] fault_mask [256];

    int checks;
    int failures;

    int exp_cnt;
    int exp_max;
    int exp_sum;
    int exp_vld;
    int exp_idx;

    approx_adder_err_scan #(.N(N), .LAT(1)) dut1 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start1),
        .o_busy          (busy1),
        .o_done          (done1),
        .o_A             (a1),
        .o_B             (b1),
        .i_Sum           (sum1),
        .i_Cout          (cout1),
        .o_err_cnt       (err_cnt1),
        .o_max_err       (max_err1),
        .o_err_sum       (err_sum1),
        .o_first_err_vld (first_vld1),
        .o_first_err_idx (first_idx1)
    );

    approx_adder_err_scan #(.N(N), .LAT(2)) dut2 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start2),
        .o_busy          (busy2),
        .o_done          (done2),
        .o_A             (a2),
        .o_B             (b2),
        .i_Sum           (sum2),
        .i_Cout          (cout2),
        .o_err_cnt       (err_cnt2),
        .o_max_err       (max_err2),
        .o_err_sum       (err_sum2),
        .o_first_err_vld (first_vld2),
        .o_first_err_idx (first_idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder models, selected by mode:
    //   0 exact
    //   1 lower two operand bits dropped
    //   2 carry stuck at 0
    //   3 exact sum XOR a per-vector random mask
    function automatic logic [4:0] adder_model(input int mode, input int a, input int b);
        int s;
        s = a + b;
        case (mode)
            1:       s = (a & 12) + (b & 12);
            2:       s = s % 16;
            3:       s = s ^ int'(fault_mask[a*16 + b]);
            default: s = s;
        endcase
        return 5'(s);
    endfunction

    always_comb begin
        {cout1, sum1} = adder_model(adder_mode, int'(a1), int'(b1));
    end

    // One-cycle registered exact adder for the LAT=2 instance.
    always_ff @(posedge clk) begin
        {cout2, sum2} <= {1'b0, a2} + {1'b0, b2};
    end

    // Reference results: walk every operand pair in index order.
    task automatic computeExpected(input int mode);
        int e;
        exp_cnt = 0;
        exp_max = 0;
        exp_sum = 0;
        exp_vld = 0;
        exp_idx = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e = int'(adder_model(mode, a, b)) - (a + b);
                if (e < 0) e = -e;
                if (e != 0) begin
                    exp_cnt++;
                    exp_sum += e;
                    if (e > exp_max) exp_max = e;
                    if (exp_vld == 0) begin
                        exp_vld = 1;
                        exp_idx = a*16 + b;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkResults1(input string tag);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt1), 32'(exp_cnt));
        checkOutput({tag, "_max_err"}, 32'(max_err1), 32'(exp_max));
        checkOutput({tag, "_err_sum"}, 32'(err_sum1), 32'(exp_sum));
        checkOutput({tag, "_first_vld"}, 32'(first_vld1), 32'(exp_vld));
        checkOutput({tag, "_first_idx"}, 32'(first_idx1), 32'(exp_idx));
    endtask

    task automatic checkAllZero1(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy1), 32'd0);
        checkOutput({tag, "_done"}, 32'(done1), 32'd0);
        checkOutput({tag, "_AB"}, 32'({a1, b1}), 32'd0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt1), 32'd0);
        checkOutput({tag, "_max_err"}, 32'(max_err1), 32'd0);
        checkOutput({tag, "_err_sum"}, 32'(err_sum1), 32'd0);
        checkOutput({tag, "_first_vld"}, 32'(first_vld1), 32'd0);
        checkOutput({tag, "_first_idx"}, 32'(first_idx1), 32'd0);
    endtask

    // Full sweep on dut1.
    //   hold keeps i_start high throughout the sweep.
    //   pulse raises i_start for one cycle mid-sweep.
    task automatic applyStimulus(input string tag, input int mode, input bit hold, input bit pulse);
        int cycles;
        bit done_seen;
        adder_mode = mode;
        computeExpected(mode);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_busy_at_start"}, 32'(busy1), 32'd1);
        checkOutput({tag, "_AB_at_start"}, 32'({a1, b1}), 32'd0);
        cycles = 0;
        done_seen = 1'b0;
        while (!done_seen && cycles < 2000) begin
            @(negedge clk);
            start1 = hold || (pulse && cycles == 300);
            @(posedge clk);
            #1;
            cycles++;
            if (done1) done_seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        checkOutput({tag, "_sweep_cycles"}, 32'(cycles), 32'd512);
        checkOutput({tag, "_busy_in_done"}, 32'(busy1), 32'd0);
        checkOutput({tag, "_AB_last"}, 32'({a1, b1}), 32'd255);
        checkResults1(tag);
        if (hold) begin
            repeat (4) @(posedge clk);
            #1;
            checkOutput({tag, "_done_held"}, 32'(done1), 32'd1);
            @(negedge clk);
            start1 = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_falls"}, 32'(done1), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy1), 32'd0);
        checkResults1({tag, "_idle"});
    endtask

    initial begin
        int cycles;
        bit done_seen;
        checks = 0;
        failures = 0;
        adder_mode = 0;
        start1 = 1'b0;
        start2 = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) fault_mask[i] = 5'd0;

        repeat (3) @(posedge clk);
        #1;
        checkAllZero1("reset");
        checkOutput("reset_dut2_busy", 32'(busy2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("exact", 0, 1'b0, 1'b0);
        applyStimulus("trunc2", 1, 1'b0, 1'b0);
        checkOutput("trunc2_known_cnt", 32'(err_cnt1), 32'd240);
        applyStimulus("stuck_cout", 2, 1'b0, 1'b0);
        checkOutput("stuck_known_idx", 32'(first_idx1), 32'd31);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) begin
                fault_mask[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            end
            applyStimulus($sformatf("random%0d", r), 3, 1'b0, 1'b0);
        end

        applyStimulus("start_pulse", 1, 1'b0, 1'b1);
        applyStimulus("start_hold", 2, 1'b1, 1'b0);

        // Abort mid-sweep around vector 100, then run a fresh sweep.
        adder_mode = 1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (199) @(negedge clk);
        checkOutput("pre_abort_busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero1("abort");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_abort", 1, 1'b0, 1'b0);

        // LAT=2 instance against the registered exact adder.
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("lat2_busy_at_start", 32'(busy2), 32'd1);
        cycles = 0;
        done_seen = 1'b0;
        while (!done_seen && cycles < 3000) begin
            @(negedge clk);
            start2 = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
            if (done2) done_seen = 1'b1;
        end
        checkOutput("lat2_done_seen", 32'(done_seen), 32'd1);
        checkOutput("lat2_sweep_cycles", 32'(cycles), 32'd768);
        checkOutput("lat2_err_cnt", 32'(err_cnt2), 32'd0);
        checkOutput("lat2_max_err", 32'(max_err2), 32'd0);
        checkOutput("lat2_err_sum", 32'(err_sum2), 32'd0);
        checkOutput("lat2_first_vld", 32'(first_vld2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
